// File: rtl/ctr_pkg.sv
// Shared constants, types and helpers for the up/down BCD counter.
package ctr_pkg;

    // Width of one packed BCD digit.
    localparam int unsigned BCD_DIGIT_W = 4;

    // Count direction encoding for the 'down' input.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Sequencer states of the shift/add-3 converter.
    typedef enum logic [1:0] {
        BCD_IDLE  = 2'd0,
        BCD_SHIFT = 2'd1,
        BCD_DONE  = 2'd2
    } bcd_state_e;

    // Ceiling log2, used to size counters from parameters.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter.
// A start pulse captures 'bin'. WIDTH shift edges follow, then one edge
// publishes the result, so 'busy' is high for WIDTH+1 cycles.
// A start during a conversion restarts it, and 'bcd' keeps its old value.
module bin2bcd_seq
    import ctr_pkg::*;
#(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          busy
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned SH_W  = BCD_W + WIDTH;
    localparam int unsigned CNT_W = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

    bcd_state_e         state_q, state_d;
    logic [SH_W-1:0]    shreg_q, shreg_d;   // {bcd scratch, remaining binary}
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               busy_q, busy_d;

    // Add 3 to every digit that is 5 or more, ahead of the next shift.
    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (r[d*BCD_DIGIT_W +: BCD_DIGIT_W] >= BCD_DIGIT_W'(5)) begin
                r[d*BCD_DIGIT_W +: BCD_DIGIT_W] = r[d*BCD_DIGIT_W +: BCD_DIGIT_W] + BCD_DIGIT_W'(3);
            end
        end
        return r;
    endfunction

    // Converter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BCD_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: start always wins, then shift, then publish.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;

        if (start) begin
            state_d = BCD_SHIFT;
            shreg_d = {{BCD_W{1'b0}}, bin};
            cnt_d   = '0;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                BCD_IDLE: begin
                    state_d = BCD_IDLE;
                end
                BCD_SHIFT: begin
                    shreg_d = {dabble_adj(shreg_q[SH_W-1 -: BCD_W]), shreg_q[WIDTH-1:0]} << 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_SHIFT) begin
                        state_d = BCD_DONE;
                    end
                end
                BCD_DONE: begin
                    bcd_d   = shreg_q[SH_W-1 -: BCD_W];
                    busy_d  = 1'b0;
                    state_d = BCD_IDLE;
                end
                default: begin
                    state_d = BCD_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;

endmodule

// File: rtl/updown_bcd_counter.sv
// Modulo-N up/down counter with prescaler, synchronous load, wrap pulse,
// sequential BCD copy of the count and two switch-selected LED banks.
module updown_bcd_counter
    import ctr_pkg::*;
#(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned MODULO = 1000,
    parameter int unsigned DIV    = 50_000_000,
    parameter int unsigned DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          hold,
    input  logic                          down,
    input  logic                          load,
    input  logic [WIDTH-1:0]              load_val,
    input  logic                          bank_sel,
    output logic [WIDTH-1:0]              count,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          bcd_busy,
    output logic                          wrap,
    output logic [WIDTH-1:0]              bank0,
    output logic [WIDTH-1:0]              bank1
);

    localparam int unsigned PSC_W = (DIV > 1) ? clog2(DIV) : 1;
    localparam int unsigned EXT_W = WIDTH + 1;
    localparam logic [PSC_W-1:0] LAST_PSC = PSC_W'(DIV - 1);
    localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MODULO - 1);

    logic [PSC_W-1:0] psc_q, psc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] bank0_q, bank0_d;
    logic [WIDTH-1:0] bank1_q, bank1_d;
    logic [WIDTH-1:0] load_clamped;
    logic             conv_start;

    // Out-of-range load values saturate at the top of the count range.
    assign load_clamped = ({1'b0, load_val} >= EXT_W'(MODULO)) ? MAX_CNT : load_val;

    // Prescaler, count, wrap and LED bank registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q   <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            bank0_q <= '0;
            bank1_q <= '0;
        end else begin
            psc_q   <= psc_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            bank0_q <= bank0_d;
            bank1_q <= bank1_d;
        end
    end

    // Per-edge priority: load, then hold, then a prescaled step.
    always_comb begin
        count_d = count_q;
        psc_d   = psc_q;
        wrap_d  = 1'b0;
        bank0_d = bank_sel ? '0 : count_q;
        bank1_d = bank_sel ? count_q : '0;

        if (load) begin
            count_d = load_clamped;
            psc_d   = '0;
        end else if (!hold) begin
            if (psc_q == LAST_PSC) begin
                psc_d = '0;
                case (down)
                    DIR_UP: begin
                        if (count_q == MAX_CNT) begin
                            count_d = '0;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end
                    DIR_DOWN: begin
                        if (count_q == '0) begin
                            count_d = MAX_CNT;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                    default: begin
                        count_d = count_q;
                    end
                endcase
            end else begin
                psc_d = psc_q + PSC_W'(1);
            end
        end
    end

    // Any edge that moves the count kicks off a fresh conversion of the new value.
    assign conv_start = (count_d != count_q);

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (count_d),
        .bcd   (bcd),
        .busy  (bcd_busy)
    );

    assign count = count_q;
    assign wrap  = wrap_q;
    assign bank0 = bank0_q;
    assign bank1 = bank1_q;

endmodule

// File: tb/tb_updown_bcd_counter.sv
// Self-checking bench for updown_bcd_counter (WIDTH=4, MODULO=10, DIV=8, DIGITS=1).
module tb_updown_bcd_counter;

    localparam int W   = 4;
    localparam int MOD = 10;
    localparam int DV  = 8;
    localparam int DG  = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hold = 1'b0;
    logic          down = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic          bank_sel = 1'b0;
    logic [W-1:0]  count;
    logic [4*DG-1:0] bcd;
    logic          bcd_busy;
    logic          wrap;
    logic [W-1:0]  bank0;
    logic [W-1:0]  bank1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    updown_bcd_counter #(
        .WIDTH  (W),
        .MODULO (MOD),
        .DIV    (DV),
        .DIGITS (DG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (hold),
        .down     (down),
        .load     (load),
        .load_val (load_val),
        .bank_sel (bank_sel),
        .count    (count),
        .bcd      (bcd),
        .bcd_busy (bcd_busy),
        .wrap     (wrap),
        .bank0    (bank0),
        .bank1    (bank1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal digits packed 4 bits each, digit 0 lowest.
    function automatic int to_bcd(input int v);
        int r;
        int x;
        r = 0;
        x = v;
        for (int d = 0; d < DG; d++) begin
            r = r | ((x % 10) << (4 * d));
            x = x / 10;
        end
        return r;
    endfunction

    // Behavioural reference: count/prescaler rules plus a conversion age tracker.
    int m_count = 0, m_psc = 0, m_wrap = 0, m_bank0 = 0, m_bank1 = 0;
    int m_bcd = 0, m_busy = 0, m_pend = 0, m_age = 0;
    int nc, nw;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count = 0; m_psc = 0; m_wrap = 0; m_bank0 = 0; m_bank1 = 0;
            m_bcd = 0; m_busy = 0; m_pend = 0; m_age = 0;
        end else begin
            nc = m_count;
            nw = 0;
            if (load) begin
                nc = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
                m_psc = 0;
            end else if (!hold) begin
                if (m_psc == DV - 1) begin
                    m_psc = 0;
                    if (!down) begin
                        nc = (m_count + 1) % MOD;
                        nw = (m_count == MOD - 1) ? 1 : 0;
                    end else begin
                        nc = (m_count + MOD - 1) % MOD;
                        nw = (m_count == 0) ? 1 : 0;
                    end
                end else begin
                    m_psc = m_psc + 1;
                end
            end
            m_bank0 = bank_sel ? 0 : m_count;
            m_bank1 = bank_sel ? m_count : 0;
            if (nc != m_count) begin
                m_pend = nc;
                m_age  = 0;
                m_busy = 1;
            end else if (m_busy != 0) begin
                m_age = m_age + 1;
                if (m_age == W + 1) begin
                    m_busy = 0;
                    m_bcd  = to_bcd(m_pend);
                end
            end
            m_count = nc;
            m_wrap  = nw;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("model_count", int'(count), m_count);
            check("model_wrap", int'(wrap), m_wrap);
            check("model_bcd", int'(bcd), m_bcd);
            check("model_busy", int'(bcd_busy), m_busy);
            check("model_bank0", int'(bank0), m_bank0);
            check("model_bank1", int'(bank1), m_bank1);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hold = 1'b0; down = 1'b0; load = 1'b0; load_val = '0; bank_sel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_bcd"}, int'(bcd), 0);
        check({tag, "_busy"}, int'(bcd_busy), 0);
        check({tag, "_wrap"}, int'(wrap), 0);
        check({tag, "_bank0"}, int'(bank0), 0);
        check({tag, "_bank1"}, int'(bank1), 0);
    endtask

    typedef struct {
        logic       hold;
        logic       down;
        logic [3:0] lv;
        int         exp_count;
    } load_vec_t;

    load_vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wraps;

        vecs[0] = '{hold: 1'b0, down: 1'b0, lv: 4'd13, exp_count: 9};
        vecs[1] = '{hold: 1'b1, down: 1'b0, lv: 4'd4,  exp_count: 4};
        vecs[2] = '{hold: 1'b0, down: 1'b1, lv: 4'd0,  exp_count: 0};
        vecs[3] = '{hold: 1'b0, down: 1'b0, lv: 4'd9,  exp_count: 9};
        vecs[4] = '{hold: 1'b1, down: 1'b1, lv: 4'd15, exp_count: 9};
        vecs[5] = '{hold: 1'b0, down: 1'b0, lv: 4'd10, exp_count: 9};
        vecs[6] = '{hold: 1'b0, down: 1'b0, lv: 4'd7,  exp_count: 7};

        // Reset state
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Free-run up from reset
        wraps = 0;
        for (int i = 1; i <= 85; i++) begin
            tick();
            if (wrap) wraps++;
            if (i == 7)  check("up_before_first_step", int'(count), 0);
            if (i == 8)  check("up_first_step", int'(count), 1);
            if (i == 12) check("up_busy_still", int'(bcd_busy), 1);
            if (i == 13) check("up_bcd_valid", int'(bcd), 1);
            if (i == 13) check("up_busy_clear", int'(bcd_busy), 0);
            if (i == 80) check("up_wrap_to_zero", int'(count), 0);
            if (i == 80) check("up_wrap_pulse", int'(wrap), 1);
        end
        check("up_wrap_pulses", wraps, 1);

        // Count down from reset
        do_reset();
        down = 1'b1;
        repeat (8) tick();
        check("down_first_step", int'(count), 9);
        check("down_first_wrap", int'(wrap), 1);
        tick();
        check("down_wrap_one_cycle", int'(wrap), 0);
        repeat (7) tick();
        check("down_second_step", int'(count), 8);
        down = 1'b0;

        // Load vectors, including clamp and load-beats-hold
        foreach (vecs[k]) begin
            load = 1'b1;
            hold = vecs[k].hold;
            down = vecs[k].down;
            load_val = vecs[k].lv;
            tick();
            check($sformatf("load_vec%0d_count", k), int'(count), vecs[k].exp_count);
            check($sformatf("load_vec%0d_wrap", k), int'(wrap), 0);
            load = 1'b0;
            hold = 1'b0;
            down = 1'b0;
        end

        // Hold freezes count and prescaler
        load = 1'b1; load_val = 4'd6;
        tick();
        load = 1'b0; hold = 1'b1;
        repeat (20) tick();
        check("hold_count_frozen", int'(count), 6);
        hold = 1'b0;
        repeat (7) tick();
        check("hold_no_early_step", int'(count), 6);
        tick();
        check("hold_step_after_release", int'(count), 7);

        // Conversion restart: old bcd goes straight to the newest value
        load = 1'b1; load_val = 4'd1;
        tick();
        load = 1'b0;
        repeat (6) tick();
        check("restart_old_bcd", int'(bcd), 1);
        load = 1'b1; load_val = 4'd3;
        tick();
        load = 1'b0;
        check("restart_hold_old_a", int'(bcd), 1);
        tick();
        check("restart_hold_old_b", int'(bcd), 1);
        load = 1'b1; load_val = 4'd7;
        tick();
        load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("restart_no_intermediate", int'((bcd == 4'd1) || (bcd == 4'd7)), 1);
            tick();
        end
        check("restart_final_bcd", int'(bcd), 7);
        check("restart_final_busy", int'(bcd_busy), 0);

        // Bank selection swap
        load = 1'b1; load_val = 4'd5; bank_sel = 1'b0;
        tick();
        load = 1'b0;
        tick();
        check("bank_sel0_bank0", int'(bank0), 5);
        check("bank_sel0_bank1", int'(bank1), 0);
        bank_sel = 1'b1;
        tick();
        check("bank_sel1_bank0", int'(bank0), 0);
        check("bank_sel1_bank1", int'(bank1), 5);

        // Asynchronous reset mid-conversion
        load = 1'b1; load_val = 4'd8;
        tick();
        load = 1'b0;
        tick();
        check("pre_reset_busy", int'(bcd_busy), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        bank_sel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) tick();
        check("post_reset_no_step", int'(count), 0);
        tick();
        check("post_reset_first_step", int'(count), 1);

        // Randomised operation against the reference model
        for (int i = 0; i < 1500; i++) begin
            hold     = ($urandom % 8) == 0;
            load     = ($urandom % 20) == 0;
            load_val = W'($urandom % 16);
            bank_sel = ($urandom % 4) == 0 ? ~bank_sel : bank_sel;
            if (($urandom % 40) == 0) down = ~down;
            tick();
        end
        hold = 1'b0;
        load = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_bcd_counter.md
# updown_bcd_counter

Parametrised modulo-N up/down counter for the FPGA lab boards. It runs from the board clock through an internal prescaler and supports hold, direction, and synchronous load. It drives a registered binary count, a sequentially converted BCD copy for the 7-segment driver, and two LED banks selected by a switch. It replaces the fixed 8-bit LED counter and sits between the debounced switch inputs and the display/LED drivers.

## Interface
Parameters:
- `WIDTH`, 10: count width in bits; must satisfy 2^WIDTH ≥ `MODULO`.
- `MODULO`, 1000: count range is 0..`MODULO`-1.
- `DIV`, 50_000_000: clocks per count step; must be ≥ `WIDTH`+2.
- `DIGITS`, 3: BCD digits; must satisfy 10^DIGITS ≥ `MODULO`.

Ports:
- `clk`  in  1: board clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `hold`  in  1: 1 freezes count and prescaler.
- `down`  in  1: 0 counts up, 1 counts down.
- `load`  in  1: synchronous load strobe.
- `load_val`  in  `WIDTH`: value to load.
- `bank_sel`  in  1: selects which LED bank shows the count.
- `count`  out  `WIDTH`: registered binary count.
- `bcd`  out  4*`DIGITS`: BCD of `count`, digit 0 in bits [3:0].
- `bcd_busy`  out  1: conversion in progress; `bcd` is stale.
- `wrap`  out  1: one-cycle pulse on wrap-around.
- `bank0`  out  `WIDTH`: LED bank 0.
- `bank1`  out  `WIDTH`: LED bank 1.

## Operation
- Reset: every register goes to 0: `count`, prescaler, `bcd`, `bcd_busy`, `wrap`, `bank0`, `bank1`.
- Prescaler `psc` counts 0..`DIV`-1 and wraps. A step occurs on the edge where `psc`==`DIV`-1.
- Priority per edge:
  1. `load`: `count` takes `load_val`. Values ≥ `MODULO` clamp to `MODULO`-1. `psc` clears. No `wrap`.
  2. `hold`: `count` and `psc` are unchanged.
  3. Step, up: `count`+1, or 0 after `MODULO`-1 with `wrap`=1.
  4. Step, down: `count`-1, or `MODULO`-1 after 0 with `wrap`=1.
- `wrap` is high only in the cycle after the wrapping edge.
- `down` is sampled only at the step edge. Changing `down` between steps has no other effect.
- BCD conversion uses sequential double-dabble.
  - Any edge that changes `count` starts a conversion and sets `bcd_busy`.
  - The conversion takes `WIDTH` shift cycles.
  - `bcd` is written and `bcd_busy` clears on the completing edge.
  - If `count` changes mid-conversion (load), the conversion restarts from the new value. `bcd` keeps its previous value.
- Banks are registered from `count`:
  - `bank_sel`=0: `bank0`=`count`, `bank1`=0.
  - `bank_sel`=1: `bank1`=`count`, `bank0`=0.

## Timing
- `count` and `wrap` update on the step or load edge (latency 1 from `load`).
- `bank0`/`bank1` lag `count` by 1 cycle. A `bank_sel` change shows on the next edge.
- `bcd` is valid `WIDTH`+1 edges after the `count` edge. `bcd_busy` is high for exactly `WIDTH`+1 cycles.
- `DIV` ≥ `WIDTH`+2 guarantees each conversion completes before the next step.
- Asserting `rst_n` mid-conversion aborts the conversion. After release, the first step occurs `DIV` edges later.

## Structure
- Shared package `ctr_pkg` holds:
  - a `clog2` function for the prescaler width;
  - constants `DIR_UP`=0 and `DIR_DOWN`=1;
  - the BCD digit width constant 4.
- Sub-module `bin2bcd_seq`, parametrised by `WIDTH` and `DIGITS`.
  - Ports: `clk`, `rst_n`, `start`, `bin`, `bcd`, `busy`.
  - It owns the shift/add-3 datapath and the shift counter.
- The top level owns the prescaler, counter, load clamp, wrap logic and bank registers.

## Test plan
All scenarios use `WIDTH`=4, `MODULO`=10, `DIV`=8, `DIGITS`=1.
- Reset then free-run up: `count` steps 0→1→…→9→0 every 8 clocks. `wrap` pulses once at 9→0. `bcd`=`count` 5 edges after each step.
- `down`=1 from reset: the first step gives 9 with `wrap`=1, then 8, 7, and so on.
- `load`=1 with `load_val`=13: `count`=9 next edge, `psc`=0, `wrap`=0. With `load_val`=4 and `hold`=1 at the same edge: `count`=4 (load wins).
- `hold`=1 for 20 clocks at `count`=6: `count` stays 6 and the next step occurs 8 clocks after `hold` drops (`psc` is frozen).
- Load 3 then load 7 two clocks later: the first conversion restarts, `bcd` goes directly from the old value to 7, and no intermediate 3 appears.
- Toggle `bank_sel` at `count`=5: the swap occurs one edge later, and the inactive bank reads 0. `rst_n` low mid-conversion: all outputs are 0 immediately, asynchronously.
